// File: rtl/avr_data_ram_ws_if.sv
// Purpose : CPU-side data port bundle for avr_data_ram_ws (request attributes, completion, clear control).
// Latency : n/a (wiring only).
// Backpressure: stall is driven by the RAM and holds the CPU until ack or clear completion.
//
// Signals:
//   req/we/addr/wdata : access request and attributes, held stable until ack
//   rdata/ack/err     : registered completion; err flags an address >= DEPTH
//   stall             : combinational CPU stall
//   clr_start/clr_busy: whole-RAM clear trigger and in-progress flag
interface avr_data_ram_ws_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   logic              stall;
   logic              clr_start;
   logic              clr_busy;

   modport master (
      output req, we, addr, wdata, clr_start,
      input  rdata, ack, err, stall, clr_busy
   );

   modport slave (
      input  req, we, addr, wdata, clr_start,
      output rdata, ack, err, stall, clr_busy
   );
endinterface

// File: rtl/avr_data_ram_ws.sv
// Purpose : AVR data RAM with req/ack handshake, programmable wait states, range error and self-timed clear.
// Latency : ack WAIT_STATES+1 cycles after acceptance; a clear occupies DEPTH cycles.
// Backpressure: stall = (req & ~ack) | clr_busy; one access in flight, no accept in the ack cycle.
//
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset (RAM contents untouched)
//   bus : slave side of avr_data_ram_ws_if (req/we/addr/wdata in; rdata/ack/err/stall out;
//         clr_start in; clr_busy out)
module avr_data_ram_ws #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 2048,
   parameter int WAIT_STATES = 1
) (
   input  logic               CLK,
   input  logic               RST,
   avr_data_ram_ws_if.slave   bus
);

   localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [3:0]        WS_L      = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_CLEAR
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        wcnt;
   logic [ADDR_W-1:0] clr_ptr;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              ack_q;
   logic              err_q;
   logic              clr_busy_q;

   logic [DATA_W-1:0] mem [DEPTH];

   // Attributes of the access that completes on this edge. With zero wait
   // states the access goes straight from IDLE to ACK, so the live bus
   // values are used before they have been latched.
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              in_range;
   logic              enter_ack;
   logic              accept;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            // Clear wins over a simultaneous request; that request stays stalled.
            if (bus.clr_start) begin
               state_nxt = S_CLEAR;
            end else if (bus.req) begin
               accept    = 1'b1;
               state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            if (wcnt <= 4'd1) begin
               state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            state_nxt = S_IDLE;
         end
         S_CLEAR: begin
            if (clr_ptr == LAST_PTR) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      if (state == S_IDLE) begin
         acc_we    = bus.we;
         acc_addr  = bus.addr;
         acc_wdata = bus.wdata;
      end
      in_range  = ({1'b0, acc_addr} < DEPTH_L);
      enter_ack = (state_nxt == S_ACK);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         wcnt       <= 4'd0;
         clr_ptr    <= '0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         clr_busy_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         ack_q      <= enter_ack;
         err_q      <= enter_ack && !in_range;
         clr_busy_q <= (state_nxt == S_CLEAR);

         if (accept) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            wcnt      <= WS_L;
         end else if (state == S_WAIT) begin
            wcnt <= wcnt - 4'd1;
         end

         if (state == S_IDLE && bus.clr_start) begin
            clr_ptr <= '0;
         end else if (state == S_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
         end

         // Reads update rdata; writes leave the last read value on the bus.
         if (enter_ack && !acc_we) begin
            rdata_q <= in_range ? mem[acc_addr[IDX_W-1:0]] : '0;
         end
      end
   end

   // RAM array has no reset; RST only blocks a write on the reset edge so an
   // aborted access or clear commits nothing further.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state == S_CLEAR) begin
            mem[clr_ptr[IDX_W-1:0]] <= '0;
         end else if (enter_ack && acc_we && in_range) begin
            mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
         end
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.ack      = ack_q;
   assign bus.err      = err_q;
   assign bus.clr_busy = clr_busy_q;
   assign bus.stall    = (bus.req & ~ack_q) | clr_busy_q;

endmodule

// File: tb/tb_avr_data_ram_ws.sv
// Purpose : self-checking bench for avr_data_ram_ws (scoreboard + behavioural RAM model).
// Latency : expects ack exactly WS+1 cycles after the RAM becomes idle with req high.
// Backpressure: driver holds req until ack; stall and clr_busy checked every cycle.
module tb_avr_data_ram_ws;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1024;
   localparam int WS     = 2;

   typedef struct {
      int               cyc;
      logic [DATA_W-1:0] rdata;
      logic             err;
   } exp_t;

   logic CLK;
   logic RST;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 0;
   int   clr_lo = 1;
   int   clr_hi = 0;

   exp_t              sb_q[$];
   logic [DATA_W-1:0] mem_m [DEPTH];
   logic [DATA_W-1:0] last_rd;

   avr_data_ram_ws_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   avr_data_ram_ws #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WS)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every ack, checks stall/clr_busy every cycle.
   always @(negedge CLK) begin
      if (mon_en) begin
         exp_t e;
         bit   clr_win;
         clr_win = (cyc >= clr_lo) && (cyc <= clr_hi);
         check("clr_busy", 32'(bus.clr_busy), 32'(clr_win));
         check("stall", 32'(bus.stall), 32'((bus.req && !bus.ack) || clr_win));
         if (bus.ack) begin
            if (sb_q.size() == 0) begin
               check("spurious_ack", 32'(bus.ack), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("ack_cycle", 32'(cyc), 32'(e.cyc));
               check("rdata", 32'(bus.rdata), 32'(e.rdata));
               check("err", 32'(bus.err), 32'(e.err));
            end
         end
      end
   end

   task automatic chk_reset();
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
   endtask

   // Entry: #1 after a posedge, in a cycle where the RAM becomes idle after
   // 'extra' more cycles (0 = idle now). Exit: #1 after the posedge that
   // follows the ack cycle, RAM idle.
   task automatic access(input bit w, input int a, input logic [DATA_W-1:0] d,
                         input int extra, input bit scr);
      exp_t e;
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = ADDR_W'(a);
      bus.wdata = d;
      e.cyc = cyc + extra + 1 + WS;
      if (a < DEPTH) begin
         if (w) mem_m[a] = d;
         else   last_rd = mem_m[a];
         e.err = 1'b0;
      end else begin
         if (!w) last_rd = '0;
         e.err = 1'b1;
      end
      e.rdata = last_rd;
      sb_q.push_back(e);
      @(posedge CLK); #1;
      bus.clr_start = 1'b0;
      if (scr && extra == 0) begin
         bus.we    = 1'($urandom);
         bus.addr  = ADDR_W'($urandom);
         bus.wdata = DATA_W'($urandom);
      end
      repeat (extra + WS) @(posedge CLK);
      @(negedge CLK); #1;
      check("ack_seen", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n);
      bus.req = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // abort_ptr < 0: full clear. Otherwise RST is sampled while the clear
   // pointer equals abort_ptr, so words below it end up zero.
   task automatic do_clear(input int abort_ptr);
      int n;
      n = (abort_ptr < 0) ? DEPTH : abort_ptr;
      clr_lo = cyc + 1;
      clr_hi = (abort_ptr < 0) ? cyc + DEPTH : cyc + 1 + abort_ptr;
      for (int i = 0; i < n; i++) mem_m[i] = '0;
      bus.clr_start = 1'b1;
      @(posedge CLK); #1;
      bus.clr_start = 1'b0;
      if (abort_ptr < 0) begin
         repeat (DEPTH) @(posedge CLK);
         #1;
      end else begin
         repeat (abort_ptr) @(posedge CLK);
         #1;
         RST = 1'b1;
         @(posedge CLK); #1;
         RST = 1'b0;
         last_rd = '0;
         chk_reset();
      end
   endtask

   initial begin
      int r, a;
      RST = 1'b1;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.clr_start = 1'b0;
      last_rd = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset();
      check("rst_stall", 32'(bus.stall), 32'd0);
      RST = 1'b0;
      mon_en = 1'b1;

      do_clear(-1);

      // Basic write then read, with and without an idle gap.
      access(1'b1, 'h010, 8'hA5, 0, 1'b0); idle(1);
      access(1'b0, 'h010, 8'h00, 0, 1'b0);
      // Top in-range word; rdata must hold across a later write.
      access(1'b1, DEPTH-1, 8'h3C, 0, 1'b0); idle(0);
      access(1'b0, DEPTH-1, 8'h00, 0, 1'b0); idle(2);
      access(1'b1, 'h011, 8'h5A, 0, 1'b1); idle(0);
      // Out-of-range write/read, then RAM unchanged.
      access(1'b1, DEPTH, 8'hFF, 0, 1'b0); idle(0);
      access(1'b0, DEPTH, 8'h00, 0, 1'b0); idle(0);
      access(1'b0, 'h000, 8'h00, 0, 1'b0); idle(1);

      // Fill, then clear with a read of addr 5 requested in the same cycle.
      for (int i = 0; i < 8; i++) begin
         access(1'b1, i, DATA_W'(8'h11 + i), 0, 1'b0);
      end
      idle(1);
      clr_lo = cyc + 1;
      clr_hi = cyc + DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      bus.clr_start = 1'b1;
      access(1'b0, 5, 8'h00, DEPTH + 1, 1'b0);
      idle(1);

      // Write aborted by reset in its first wait cycle.
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = ADDR_W'('h020); bus.wdata = 8'h77;
      @(posedge CLK); #1;
      RST = 1'b1;
      bus.req = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      last_rd = '0;
      chk_reset();
      idle(3);
      access(1'b0, 'h020, 8'h00, 0, 1'b0); idle(1);

      // Clear aborted by reset at pointer 4.
      for (int i = 0; i < 8; i++) begin
         access(1'b1, i, DATA_W'(8'h21 + i), 0, 1'b0);
      end
      idle(1);
      do_clear(4);
      idle(1);
      for (int i = 0; i < 8; i++) begin
         access(1'b0, i, 8'h00, 0, 1'b0);
      end
      idle(1);

      // Random traffic; gap 0 keeps req high across accesses.
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      a = $urandom_range(0, 15);
         else if (r < 8) a = $urandom_range(DEPTH - 4, DEPTH - 1);
         else            a = $urandom_range(DEPTH, (1 << ADDR_W) - 1);
         access(1'($urandom_range(0, 1)), a, DATA_W'($urandom), 0,
                ($urandom_range(0, 3) == 0));
         idle($urandom_range(0, 2));
      end

      idle(3);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avr_data_ram_ws.md
Name: avr_data_ram_ws

Overview:
- Parametrised synchronous data RAM for the AVR core. It replaces the fixed 2048x8, zero-latency data memory used by the CPU benches.
- Adds a req/ack handshake, a programmable number of wait states, a stall output toward the CPU, out-of-range error signalling and a self-timed bulk-clear sequencer.
- Sits between the CPU data port (d_addr/data_write) and the bench or top-level.
- Uses separate read and write data buses; there is no inout bus.

Parameters:
- ADDR_W, 11: address width.
- DATA_W, 8: data word width.
- DEPTH, 2048: number of words implemented. Must satisfy DEPTH <= 2**ADDR_W.
- WAIT_STATES, 1: extra cycles inserted before each access completes. Legal range 0..15.

Ports:
- CLK  in  1  clock; all logic updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req  in  1  access request. Held high, with all attributes stable, until ack.
- we  in  1  1 = write, 0 = read. Sampled at acceptance.
- addr  in  ADDR_W  word address. Sampled at acceptance.
- wdata  in  DATA_W  write data. Sampled at acceptance.
- rdata  out  DATA_W  read data. Registered; valid in the ack cycle and held until the next read completes.
- ack  out  1  one-cycle completion pulse.
- err  out  1  pulses with ack when the access address is >= DEPTH.
- stall  out  1  combinational: (req & ~ack) | clr_busy. Drives the CPU stall input.
- clr_start  in  1  single-cycle pulse requesting a clear of the whole RAM to zero.
- clr_busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (RST=1 at an edge):
  - State goes to IDLE.
  - rdata=0, ack=0, err=0, clr_busy=0.
  - Wait counter and clear pointer go to 0.
  - RAM contents are NOT modified by reset. Simulation initialises all words to 0.
- States: IDLE, WAIT, ACK, CLEAR.
- IDLE:
  - clr_start=1: go to CLEAR, pointer=0. This takes priority over a simultaneous req; that req stays stalled.
  - Otherwise req=1: latch we/addr/wdata, load counter=WAIT_STATES, go to WAIT.
    - If WAIT_STATES=0, go directly to ACK instead.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 1, the next state is ACK.
- Entering ACK (the same edge that raises ack):
  - Write with latched addr < DEPTH: ram[addr] <= wdata.
  - Read with addr < DEPTH: rdata <= ram[addr].
  - Out-of-range write: dropped, no RAM change, err=1.
  - Out-of-range read: rdata <= 0, err=1.
  - Writes leave rdata unchanged.
- ACK:
  - Lasts exactly one cycle, then return to IDLE.
  - A req still high in the following IDLE cycle is a new access. There are no back-to-back accepts from ACK.
- Latency:
  - Acceptance at cycle N gives ack at cycle N+1+WAIT_STATES.
  - Access occupancy is 2+WAIT_STATES cycles (including the IDLE accept cycle).
- CLEAR:
  - Write 0 to ram[pointer] and increment pointer, one word per cycle.
  - clr_busy is high for exactly DEPTH cycles.
  - After the write to DEPTH-1, go to IDLE and drop clr_busy.
  - req is ignored (stalled) throughout. clr_start during CLEAR is ignored; no restart.
- Read-after-write: a read of the same address accepted in the IDLE cycle after a write's ACK returns the new data.
- Reset in any state:
  - An in-flight access is aborted and not committed: no write, no ack.
  - A clear is abandoned and the words already cleared stay zero.
- Protocol violation: changing we/addr/wdata while stalled has no effect, because attributes were latched at acceptance.
- ack, err and rdata are registered. stall is the only combinational output.

Test Plan:
- WAIT_STATES=0: write 0xA5 to addr 0x010, then read 0x010 → each ack arrives 1 cycle after accept, rdata=0xA5, err=0, stall high only during the accept cycle.
- WAIT_STATES=3: read addr 0x7FF after writing 0x3C there → ack at accept+4, stall high 4 cycles, rdata=0x3C; rdata holds 0x3C through a subsequent write ack.
- DEPTH=1024, ADDR_W=11: write 0xFF to 0x400, then read 0x400 → both ack with err=1, read rdata=0x00; a read of 0x000 shows the RAM unchanged.
- Fill addr 0..7 with 0x11..0x18, pulse clr_start with req=1 in the same cycle → clr_busy high exactly DEPTH cycles, then the pending read of addr 5 completes with 0x00.
- WAIT_STATES=2: accept a write of 0x77 to 0x020, assert RST in the first WAIT cycle → no ack, and a later read of 0x020 returns its old value 0x00. Separately, RST mid-CLEAR at pointer 4 → addr 0..3 read 0, addr 4..7 keep their old values.
- Hold req high continuously for 3 reads with WAIT_STATES=1 → acks at cycles 2, 5 and 8 after first accept (one IDLE cycle between accesses), with correct data each time.
